// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master drives the operation request; the slave returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first. Subtraction is A + ~B + 1.
// The result registers only change on the edge that enters DONE, so no
// partially computed word is ever visible on sum.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic last_bit;
  logic fa_s;
  logic fa_c;

  // A request is honoured only when no operation is being shifted through.
  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  // The single full-adder cell working on the current LSBs.
  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE lasts one cycle unless a new request chains on.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift one bit per RUN cycle,
  // publish the finished word on the last bit.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      a_d   = bus.a;
      b_d   = bus.sub ? ~bus.b : bus.b;
      c_d   = bus.sub ? 1'b1 : bus.cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_c;
      r_d   = {fa_s, r_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        sum_d  = {fa_s, r_q[WIDTH-1:1]};
        cout_d = fa_c;
        // c_q is the carry into the MSB cell, fa_c the carry out of it.
        ovf_d  = c_q ^ fa_c;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      r_q    <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=8) with a result scoreboard.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  logic [W+1:0] sb[$];

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {cout, ovf, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0] full;
    logic       co;
    logic       ov;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      co   = full[W];
      ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b};
      co   = (a >= b);
      ov   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {co, ov, full[W-1:0]};
  endfunction

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sum", bus.sum, e[W-1:0]);
        chk("cout", bus.cout, e[W+1]);
        chk("ovf", bus.ovf, e[W]);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int nb;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1 bus.start = 1'b0;
    nb   = 0;
    seen = 0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (bus.done) begin
        chk("latency", k, W + 1);
        seen = 1;
        break;
      end
      if (bus.busy) nb++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("busy_cycles", nb, W);
    @(negedge clk);
    chk("done_pulse_width", bus.done, 0);
  endtask

  task automatic wait_done(input int budget, output int k_done);
    k_done = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.done) begin
        k_done = k;
        break;
      end
    end
    if (k_done < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int kd;
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    // Start is asserted during reset and must not be taken.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // Directed add/sub cases.
    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(8'h0F, 8'h10, 1'b1, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 1'b1);
    do_op(8'h80, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

    // A start pulse while running must be ignored.
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.sub = 1'b0;
    sb.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(W + 4, kd);
    chk("midrun_latency", kd + 4, W + 1);
    repeat (W + 3) @(negedge clk);
    chk("midrun_done_count", done_cnt - d0, 1);

    // Start held high through DONE chains a second operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b0; bus.sub = 1'b0;
    sb.push_back(model(8'h33, 8'h44, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.a = 8'h01; bus.b = 8'h01;
    sb.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    wait_done(W + 3, kd);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("b2b_busy_next", bus.busy, 1);
    chk("b2b_done_low", bus.done, 0);
    chk("b2b_sum_hold", bus.sum, 8'h77);
    wait_done(W + 3, kd);
    chk("b2b_second_latency", kd, W);
    chk("b2b_sum_new", bus.sum, 8'h02);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.sub = 1'b0;
    sb.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sum", bus.sum, 0);
    chk("arst_cout", bus.cout, 0);
    chk("arst_ovf", bus.ovf, 0);
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    do_op(8'h3C, 8'hC3, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled on rising clk edge.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled only on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled only on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in for add; ignored when sub=1.
REQ-008 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B; sampled only on the accepting edge.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid new result.
REQ-011 SHALL have port sum  output  WIDTH  registered result.
REQ-012 SHALL have port cout  output  1  final carry out; for sub, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 SHALL compute bit-serially through one full-adder cell plus carry flip-flop, one bit per clk, LSB first.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE -> RUN on accepted start; RUN -> DONE after WIDTH bit-cycles; DONE -> IDLE after one cycle unless start accepted, then DONE -> RUN.
REQ-016 SHALL accept start only in IDLE or DONE; start in RUN ignored, no effect on operands or count.
REQ-017 SHALL on the accepting edge latch a; latch b for sub=0, ~b for sub=1; initialise carry to cin for sub=0, 1 for sub=1.
REQ-018 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits, cleared on accept, incremented per RUN cycle, terminal at WIDTH.
REQ-019 SHALL assert busy in the cycle after the accepting edge and hold it through the last RUN cycle; busy low in IDLE and DONE.
REQ-020 SHALL assert done exactly one cycle (DONE state), first visible after edge N+WIDTH, accepting edge = N.
REQ-021 SHALL load sum, cout, ovf on the edge entering DONE; hold them until the next completion (no partial bits visible).
REQ-022 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-023 SHALL, on back-to-back start in DONE, still pulse done that cycle, keep the old result visible until the new one completes, and raise busy the next cycle.
REQ-024 SHALL results modulo 2^WIDTH; cout captures the (WIDTH+1)th bit.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter and internal registers 0, regardless of clk.
REQ-026 SHALL abort any operation in progress on reset; no done pulse follows release.
REQ-027 SHALL ignore start while rst_n low; first acceptance possible on first rising edge with rst_n high.

Verification (WIDTH=8)
REQ-028 SHALL pass: reset, then start a=8'h00 b=8'h00 cin=0 sub=0 -> busy high 8 cycles, done single pulse 8 cycles after accepting edge, sum=8'h00 cout=0 ovf=0.
REQ-029 SHALL pass: add 8'hFF+8'h01 cin=0 -> sum=8'h00 cout=1 ovf=0; add 8'h7F+8'h01 cin=0 -> sum=8'h80 cout=0 ovf=1; add 8'h0F+8'h10 cin=1 -> sum=8'h20 cout=0 ovf=0.
REQ-030 SHALL pass: sub 8'h05-8'h07 (cin=1, ignored) -> sum=8'hFE cout=0 ovf=0; sub 8'h80-8'h01 -> sum=8'h7F cout=1 ovf=1.
REQ-031 SHALL pass: start with a=8'h11 b=8'h22 pulsed again mid-RUN with a=8'hFF -> ignored, result sum=8'h33, one done pulse.
REQ-032 SHALL pass: start held high through DONE with new operands 8'h01+8'h01 -> done pulses, busy high next cycle, sum keeps old value until second done, then 8'h02.
REQ-033 SHALL pass: rst_n low 3 cycles after accept -> busy, done, sum, cout, ovf 0 immediately (asynchronously), no done after release; next op correct.
